w5300_bus_sequencer: RTL and testbench
======================================

Name: w5300_bus_sequencer

Overview:
- Sequences every QL 68008 bus cycle aimed at the W5300 expansion card. Timed W5300 chip-select/read/write strobes replace the combinational pass-through, and DTACK is generated only once the strobe timing has elapsed.
- Owns the W5300 hardware reset: a power-up reset sequence plus a software reset triggered by a write to the card's reset register.
- Sits between the CPLD address decode (card_sel/wiz_sel/rst_sel) and the W5300 and bus-buffer pins.

Parameters:
- SETUP_CYC, 1, clk cycles with CS low before the RD/WR strobe is asserted (>=1)
- STROBE_CYC, 3, clk cycles the RD/WR strobe is held before DTACK is asserted (>=1)
- RECOVER_CYC, 1, idle clk cycles after a cycle ends before the next cycle is accepted (>=1)
- RST_CYC, 16, clk cycles wizrstl is held low
- RST_WAIT_CYC, 64, clk cycles after wizrstl rises before W5300 accesses are served
- CW, 16, counter width; must hold max(all *_CYC)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- asl  in  1  68008 address strobe, active low, asynchronous to clk
- dsl  in  1  68008 data strobe, active low, asynchronous to clk
- rdwl  in  1  68008 read/write (1 = read), asynchronous to clk
- card_sel  in  1  decoded card address (any card register), combinational from address
- wiz_sel  in  1  decoded W5300 data window (offset 0xF)
- rst_sel  in  1  decoded reset register (offset 0xE)
- dtackl  out  1  DTACK to the 68008, active low
- dbenl  out  1  data buffer enable, active low
- dbdir  out  1  data buffer direction (1 = card to CPU)
- wizcsl  out  1  W5300 chip select, active low
- wizrdl  out  1  W5300 read strobe, active low
- wizwrl  out  1  W5300 write strobe, active low
- wizrstl  out  1  W5300 reset, active low
- busy  out  1  high while a reset sequence is in progress

Behaviour:
- Synchronisation:
  - asl, dsl and rdwl each pass through a 2-flop synchroniser, giving as_s, ds_s and rw_s.
  - card_sel, wiz_sel and rst_sel are sampled in the same cycle that start is detected.
- Reset values (while rst is high):
  - dtackl=1, dbenl=1, dbdir=1, wizcsl=1, wizrdl=1, wizwrl=1, wizrstl=0, busy=1.
  - The state register is RST_PULSE and the counter is 0.
  - Deasserting rst therefore always runs the power-up reset sequence.
- start condition: as_s==0 && ds_s==0 && card_sel==1.
- On start, rw_s is latched into the direction register and dbdir follows it for the whole cycle.
- States:
  - RST_PULSE:
    - wizrstl=0, busy=1.
    - Count RST_CYC cycles, then go to RST_WAIT.
  - RST_WAIT:
    - wizrstl=1, busy=1.
    - Count RST_WAIT_CYC cycles, then go to IDLE.
    - A start during either reset state is not served; the CPU is stalled (dtackl=1) until IDLE serves it.
  - IDLE:
    - All strobes deasserted.
    - On start with wiz_sel: go to SETUP; wizcsl=0 and dbenl=0 from the next cycle.
    - On start with rst_sel: go to REG_ACK.
    - On start with neither select: go to REG_ACK (acknowledge, no data).
  - SETUP:
    - Hold SETUP_CYC cycles.
    - Then go to STROBE, asserting wizrdl=0 for a read or wizwrl=0 for a write.
  - STROBE:
    - Hold STROBE_CYC cycles, then go to ACK.
    - If ds_s returns to 1 during SETUP or STROBE, go to RECOVER immediately: all strobes off, dtackl never asserted.
  - ACK:
    - dtackl=0.
    - Read: wizcsl, wizrdl and dbenl stay low.
    - Write: wizwrl rises on entry to ACK, so the W5300 latches on that edge; wizcsl stays low for one extra cycle of hold, then rises.
    - Stay until ds_s==1, then go to RECOVER.
  - REG_ACK:
    - dtackl=0, dbenl=1, no W5300 strobes.
    - Stay until ds_s==1.
    - Then go to RST_PULSE for a write with rst_sel, otherwise to RECOVER.
  - RECOVER:
    - All outputs inactive (dtackl=1, dbenl=1, wizcsl/wizrdl/wizwrl=1).
    - Hold RECOVER_CYC cycles, then go to IDLE.
    - A new start is not detected until IDLE.
- Counter:
  - Clears on every state entry.
  - The state exits when the counter equals (param - 1).
  - No wrap is possible, given CW sizing.
- Invariants:
  - wizrdl and wizwrl are never both 0.
  - wizrdl and wizwrl are never 0 while wizcsl=1.
  - dtackl is only 0 in ACK or REG_ACK.
- An asynchronous rst at any point immediately forces the reset values, including mid-strobe.

Test Plan:
- Power-up: rst high for 3 cycles, then released -> wizrstl=0 for 16 cycles, busy=1 for 80 cycles total, then IDLE with all outputs inactive.
- W5300 read, wiz_sel=1, rdwl=1, dsl held low -> wizcsl low 2 sync cycles + 1 after dsl falls; wizrdl low 1 cycle later; dtackl low 3 cycles after that; all released 1 cycle after ds_s rises.
- W5300 write, rdwl=0 -> wizwrl low exactly 3 cycles and rising on the cycle dtackl falls; dbdir=0 throughout; wizcsl rises 1 cycle after wizwrl.
- Reset register write, rst_sel=1 -> dtackl low with dbenl=1; after dsl rises, wizrstl=0 for 16 cycles; a wiz_sel read issued during RST_WAIT gets dtackl only after busy falls.
- Aborted cycle: dsl raised during STROBE -> strobes deassert next cycle, dtackl stays 1, IDLE reached after 1 recovery cycle.
- rst asserted while wizwrl=0 -> wizwrl=1, wizcsl=1, wizrstl=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/w5300_bus_sequencer.sv
// -----------------------------------------------------------------------------
// w5300_bus_sequencer
//
// Sequences every QL 68008 bus cycle aimed at the W5300 expansion card. It
// produces timed W5300 chip-select/read/write strobes and returns DTACK only
// once the strobe timing has elapsed. It also owns the W5300 hardware reset,
// which runs at power-up and again after a write to the card's reset register.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset (forces the power-up sequence)
//   asl       68008 address strobe, active low, asynchronous
//   dsl       68008 data strobe, active low, asynchronous
//   rdwl      68008 read/write (1 = read), asynchronous
//   card_sel  decoded card address (any card register)
//   wiz_sel   decoded W5300 data window
//   rst_sel   decoded reset register
//   dtackl    DTACK to the 68008, active low
//   dbenl     data buffer enable, active low
//   dbdir     data buffer direction (1 = card to CPU)
//   wizcsl    W5300 chip select, active low
//   wizrdl    W5300 read strobe, active low
//   wizwrl    W5300 write strobe, active low
//   wizrstl   W5300 reset, active low
//   busy      high while a reset sequence is in progress
// -----------------------------------------------------------------------------
module w5300_bus_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 3,
  parameter int unsigned RECOVER_CYC  = 1,
  parameter int unsigned RST_CYC      = 16,
  parameter int unsigned RST_WAIT_CYC = 64,
  parameter int unsigned CW           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic asl,
  input  logic dsl,
  input  logic rdwl,
  input  logic card_sel,
  input  logic wiz_sel,
  input  logic rst_sel,
  output logic dtackl,
  output logic dbenl,
  output logic dbdir,
  output logic wizcsl,
  output logic wizrdl,
  output logic wizwrl,
  output logic wizrstl,
  output logic busy
);

  localparam logic [CW-1:0] SETUP_LAST    = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST   = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] RECOVER_LAST  = CW'(RECOVER_CYC - 1);
  localparam logic [CW-1:0] RST_LAST      = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] RST_WAIT_LAST = CW'(RST_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_RST_PULSE,
    S_RST_WAIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_ACK,
    S_REG_ACK,
    S_RECOVER
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_as_m, r_as_s;
  logic            r_ds_m, r_ds_s;
  logic            r_rw_m, r_rw_s;
  logic            r_dir;
  logic            r_rsel;
  logic            r_dtackl;
  logic            r_dbenl;
  logic            r_csl;
  logic            r_rdl;
  logic            r_wrl;
  logic            r_rstl;
  logic            r_busy;
  logic            w_start;

  assign w_start = !r_as_s && !r_ds_s && card_sel;

  assign dtackl  = r_dtackl;
  assign dbenl   = r_dbenl;
  assign dbdir   = r_dir;
  assign wizcsl  = r_csl;
  assign wizrdl  = r_rdl;
  assign wizwrl  = r_wrl;
  assign wizrstl = r_rstl;
  assign busy    = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_as_m   <= 1'b1;
      r_as_s   <= 1'b1;
      r_ds_m   <= 1'b1;
      r_ds_s   <= 1'b1;
      r_rw_m   <= 1'b1;
      r_rw_s   <= 1'b1;
      r_state  <= S_RST_PULSE;
      r_cnt    <= '0;
      r_dir    <= 1'b1;
      r_rsel   <= 1'b0;
      r_dtackl <= 1'b1;
      r_dbenl  <= 1'b1;
      r_csl    <= 1'b1;
      r_rdl    <= 1'b1;
      r_wrl    <= 1'b1;
      r_rstl   <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_as_m <= asl;
      r_as_s <= r_as_m;
      r_ds_m <= dsl;
      r_ds_s <= r_ds_m;
      r_rw_m <= rdwl;
      r_rw_s <= r_rw_m;

      // Saturating count; every state transition below overrides this with '0.
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_RST_PULSE: begin
          if (r_cnt == RST_LAST) begin
            r_state <= S_RST_WAIT;
            r_cnt   <= '0;
            r_rstl  <= 1'b1;
          end
        end

        S_RST_WAIT: begin
          if (r_cnt == RST_WAIT_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end

        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_dir  <= r_rw_s;
            r_rsel <= rst_sel;
            if (wiz_sel) begin
              r_state <= S_SETUP;
              r_csl   <= 1'b0;
              r_dbenl <= 1'b0;
            end else begin
              r_state  <= S_REG_ACK;
              r_dtackl <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          if (r_ds_s) begin
            r_state <= S_RECOVER;
            r_cnt   <= '0;
            r_dbenl <= 1'b1;
            r_csl   <= 1'b1;
            r_rdl   <= 1'b1;
            r_wrl   <= 1'b1;
          end else if (r_cnt == SETUP_LAST) begin
            r_state <= S_STROBE;
            r_cnt   <= '0;
            if (r_dir) r_rdl <= 1'b0;
            else       r_wrl <= 1'b0;
          end
        end

        S_STROBE: begin
          // A released data strobe wins over strobe completion: DTACK must
          // never be returned to a cycle the CPU has already abandoned.
          if (r_ds_s) begin
            r_state <= S_RECOVER;
            r_cnt   <= '0;
            r_dbenl <= 1'b1;
            r_csl   <= 1'b1;
            r_rdl   <= 1'b1;
            r_wrl   <= 1'b1;
          end else if (r_cnt == STROBE_LAST) begin
            r_state  <= S_ACK;
            r_cnt    <= '0;
            r_dtackl <= 1'b0;
            r_wrl    <= 1'b1;
          end
        end

        S_ACK: begin
          if (r_ds_s) begin
            r_state  <= S_RECOVER;
            r_cnt    <= '0;
            r_dtackl <= 1'b1;
            r_dbenl  <= 1'b1;
            r_csl    <= 1'b1;
            r_rdl    <= 1'b1;
            r_wrl    <= 1'b1;
          end else if (r_cnt == '0 && !r_dir) begin
            // Write: chip select held one cycle past the WR rising edge.
            r_csl <= 1'b1;
          end
        end

        S_REG_ACK: begin
          if (r_ds_s) begin
            r_dtackl <= 1'b1;
            r_cnt    <= '0;
            if (r_rsel && !r_dir) begin
              r_state <= S_RST_PULSE;
              r_rstl  <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_RECOVER;
            end
          end
        end

        S_RECOVER: begin
          if (r_cnt == RECOVER_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end

        default: begin
          r_state <= S_RECOVER;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_bus_sequencer.sv
module tb_w5300_bus_sequencer;

  logic clk;
  logic rst;
  logic asl, dsl, rdwl;
  logic card_sel, wiz_sel, rst_sel;
  logic dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy;
  logic [7:0] w_obs;

  int checks;
  int errors;

  // Output vector order: {dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy}
  localparam logic [7:0] V_RST     = 8'b1111_1101;
  localparam logic [7:0] V_WAIT_R  = 8'b1111_1111;
  localparam logic [7:0] V_IDLE_R  = 8'b1111_1110;
  localparam logic [7:0] V_IDLE_W  = 8'b1101_1110;
  localparam logic [7:0] V_SETUP_R = 8'b1010_1110;
  localparam logic [7:0] V_SETUP_W = 8'b1000_1110;
  localparam logic [7:0] V_STB_R   = 8'b1010_0110;
  localparam logic [7:0] V_STB_W   = 8'b1000_1010;
  localparam logic [7:0] V_ACK_R   = 8'b0010_0110;
  localparam logic [7:0] V_ACK_W0  = 8'b0000_1110;
  localparam logic [7:0] V_ACK_W1  = 8'b0001_1110;
  localparam logic [7:0] V_REG_R   = 8'b0111_1110;
  localparam logic [7:0] V_REG_W   = 8'b0101_1110;
  localparam logic [7:0] V_PULSE_W = 8'b1101_1101;
  localparam logic [7:0] V_WAIT_W  = 8'b1101_1111;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  w5300_bus_sequencer #(
    .SETUP_CYC    (1),
    .STROBE_CYC   (3),
    .RECOVER_CYC  (1),
    .RST_CYC      (16),
    .RST_WAIT_CYC (64),
    .CW           (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .asl      (asl),
    .dsl      (dsl),
    .rdwl     (rdwl),
    .card_sel (card_sel),
    .wiz_sel  (wiz_sel),
    .rst_sel  (rst_sel),
    .dtackl   (dtackl),
    .dbenl    (dbenl),
    .dbdir    (dbdir),
    .wizcsl   (wizcsl),
    .wizrdl   (wizrdl),
    .wizwrl   (wizwrl),
    .wizrstl  (wizrstl),
    .busy     (busy)
  );

  assign w_obs = {dtackl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe-pairing invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(!wizrdl && !wizwrl) && !((!wizrdl || !wizwrl) && wizcsl)) else begin
        errors++;
        $error("FAIL invariant: observed cs=%b rd=%b wr=%b expected no rd/wr overlap and no strobe without cs",
               wizcsl, wizrdl, wizwrl);
      end
    end
  end

  task automatic push(input string tag, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.tag = $sformatf("%s[%0d]", tag, i);
      e.v   = v;
      sb.push_back(e);
    end
  endtask

  task automatic compare(input exp_t e);
    checks++;
    assert (w_obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", e.tag, w_obs, e.v);
    end
  endtask

  // One expected entry per clock: advance one cycle, sample on the falling edge.
  task automatic run();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk);
      @(negedge clk);
      compare(e);
    end
  endtask

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    compare(e);
  endtask

  task automatic bus_start(input logic rw, input logic wsel, input logic rsel);
    asl      = 1'b0;
    dsl      = 1'b0;
    rdwl     = rw;
    card_sel = 1'b1;
    wiz_sel  = wsel;
    rst_sel  = rsel;
  endtask

  task automatic bus_end();
    asl      = 1'b1;
    dsl      = 1'b1;
    rdwl     = 1'b1;
    card_sel = 1'b0;
    wiz_sel  = 1'b0;
    rst_sel  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus_end();

    // Power-up
    #1;
    push("rst_val", V_RST, 1);
    check_now();
    push("rst_hold", V_RST, 3);
    run();
    rst = 1'b0;
    push("pwr_pulse", V_RST, 15);
    push("pwr_wait", V_WAIT_R, 64);
    push("pwr_idle", V_IDLE_R, 2);
    run();

    // W5300 read
    bus_start(1'b1, 1'b1, 1'b0);
    push("rd_sync", V_IDLE_R, 2);
    push("rd_setup", V_SETUP_R, 1);
    push("rd_strobe", V_STB_R, 3);
    push("rd_ack", V_ACK_R, 3);
    run();
    bus_end();
    push("rd_ack_hold", V_ACK_R, 2);
    push("rd_release", V_IDLE_R, 2);
    run();

    // W5300 write
    bus_start(1'b0, 1'b1, 1'b0);
    push("wr_sync", V_IDLE_R, 2);
    push("wr_setup", V_SETUP_W, 1);
    push("wr_strobe", V_STB_W, 3);
    push("wr_ack_cs", V_ACK_W0, 1);
    push("wr_ack", V_ACK_W1, 2);
    run();
    bus_end();
    push("wr_ack_hold", V_ACK_W1, 2);
    push("wr_release", V_IDLE_W, 2);
    run();

    // Card register read with neither select
    bus_start(1'b1, 1'b0, 1'b0);
    push("reg_sync", V_IDLE_W, 2);
    push("reg_ack", V_REG_R, 2);
    run();
    bus_end();
    push("reg_ack_hold", V_REG_R, 2);
    push("reg_release", V_IDLE_R, 2);
    run();

    // Reset register write, then a W5300 read issued during RST_WAIT
    bus_start(1'b0, 1'b0, 1'b1);
    push("swr_sync", V_IDLE_R, 2);
    push("swr_ack", V_REG_W, 2);
    run();
    bus_end();
    push("swr_ack_hold", V_REG_W, 2);
    push("swr_pulse", V_PULSE_W, 16);
    push("swr_wait", V_WAIT_W, 10);
    run();
    bus_start(1'b1, 1'b1, 1'b0);
    push("stall_wait", V_WAIT_W, 54);
    push("stall_idle", V_IDLE_W, 1);
    push("stall_setup", V_SETUP_R, 1);
    push("stall_strobe", V_STB_R, 3);
    push("stall_ack", V_ACK_R, 2);
    run();
    bus_end();
    push("stall_ack_hold", V_ACK_R, 2);
    push("stall_release", V_IDLE_R, 2);
    run();

    // Aborted read: data strobe released during STROBE
    bus_start(1'b1, 1'b1, 1'b0);
    push("abt_sync", V_IDLE_R, 2);
    push("abt_setup", V_SETUP_R, 1);
    push("abt_strobe", V_STB_R, 1);
    run();
    bus_end();
    push("abt_strobe_hold", V_STB_R, 2);
    push("abt_recover", V_IDLE_R, 1);
    push("abt_idle", V_IDLE_R, 1);
    run();

    // Asynchronous reset while the write strobe is low
    bus_start(1'b0, 1'b1, 1'b0);
    push("arst_sync", V_IDLE_R, 2);
    push("arst_setup", V_SETUP_W, 1);
    push("arst_strobe", V_STB_W, 1);
    run();
    #2;
    rst = 1'b1;
    bus_end();
    #1;
    push("arst_immediate", V_RST, 1);
    check_now();
    push("arst_hold", V_RST, 2);
    run();
    rst = 1'b0;
    push("arst_pulse", V_RST, 15);
    push("arst_wait", V_WAIT_R, 64);
    push("arst_idle", V_IDLE_R, 1);
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
